// File: rtl/vec_result_writeback.sv
// Captures a pair of result vectors and streams them to memory one word per
// accepted write: low lanes first, then high lanes, followed by a done pulse.
module vec_result_writeback #(
   parameter int LANES  = 16,
   parameter int WORD_W = 32,
   parameter int ADDR_W = 10
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [LANES*WORD_W-1:0]   res_lo,
   input  logic [LANES*WORD_W-1:0]   res_hi,
   input  logic [ADDR_W-1:0]         base_addr,
   input  logic                      mem_ready,
   output logic                      mem_we,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [WORD_W-1:0]         mem_wdata,
   output logic                      busy,
   output logic                      done
);

   localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

   typedef enum logic [1:0] {
      IDLE,
      WR_LO,
      WR_HI,
      FINISH
   } state_t;

   state_t                  r_state;
   state_t                  w_state_next;
   logic [CNT_W-1:0]        r_cnt;
   logic [CNT_W-1:0]        w_cnt_next;
   logic [LANES*WORD_W-1:0] r_lo;
   logic [LANES*WORD_W-1:0] r_hi;
   logic [ADDR_W-1:0]       r_base;
   logic                    w_capture;
   logic                    w_last;

   // NOTE: every signal driven here gets a default first so no path leaves it
   // unassigned; otherwise synthesis would infer a latch to hold its old value.
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_capture    = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      busy         = (r_state != IDLE);
      done         = 1'b0;
      w_last       = (r_cnt == CNT_W'(LANES - 1));

      case (r_state)
         IDLE: begin
            if (start) begin
               w_capture    = 1'b1;
               w_cnt_next   = '0;
               w_state_next = WR_LO;
            end
         end
         WR_LO: begin
            mem_we    = 1'b1;
            mem_addr  = r_base + ADDR_W'(r_cnt);
            mem_wdata = r_lo[WORD_W*r_cnt +: WORD_W];
            if (mem_ready) begin
               if (w_last) begin
                  w_cnt_next   = '0;
                  w_state_next = WR_HI;
               end else begin
                  w_cnt_next = r_cnt + CNT_W'(1);
               end
            end
         end
         WR_HI: begin
            // High words land directly after the low block; the sum wraps.
            mem_we    = 1'b1;
            mem_addr  = r_base + ADDR_W'(LANES) + ADDR_W'(r_cnt);
            mem_wdata = r_hi[WORD_W*r_cnt +: WORD_W];
            if (mem_ready) begin
               if (w_last) begin
                  w_cnt_next   = '0;
                  w_state_next = FINISH;
               end else begin
                  w_cnt_next = r_cnt + CNT_W'(1);
               end
            end
         end
         FINISH: begin
            done         = 1'b1;
            w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   // NOTE: the captured vectors are ordinary flops, not a RAM, so they can be
   // cleared by reset along with the control state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_lo    <= '0;
         r_hi    <= '0;
         r_base  <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         if (w_capture) begin
            r_lo   <= res_lo;
            r_hi   <= res_hi;
            r_base <= base_addr;
         end
      end
   end

endmodule

// File: tb/tb_vec_result_writeback.sv
// Randomized bench for vec_result_writeback: a queue of expected (addr, data)
// writes is built from the captured inputs and drained on each accepted write.
module tb_vec_result_writeback;

   localparam int LANES  = 16;
   localparam int WORD_W = 32;
   localparam int ADDR_W = 10;
   localparam int VEC_W  = LANES * WORD_W;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [VEC_W-1:0]  res_lo;
   logic [VEC_W-1:0]  res_hi;
   logic [ADDR_W-1:0] base_addr;
   logic              mem_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [WORD_W-1:0] mem_wdata;
   logic              busy;
   logic              done;

   vec_result_writeback #(
      .LANES (LANES),
      .WORD_W(WORD_W),
      .ADDR_W(ADDR_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .res_lo   (res_lo),
      .res_hi   (res_hi),
      .base_addr(base_addr),
      .mem_ready(mem_ready),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [WORD_W-1:0] data;
   } wr_t;

   wr_t exp_q[$];
   int  n_cmp = 0;
   int  n_err = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [VEC_W-1:0] rand_vec();
      logic [VEC_W-1:0] v;
      for (int i = 0; i < LANES; i++) v[WORD_W*i +: WORD_W] = $urandom;
      return v;
   endfunction

   // Expected stream: word k of the 2*LANES sequence goes to base+k (mod 2^ADDR_W).
   task automatic build_model(input logic [VEC_W-1:0] lo, input logic [VEC_W-1:0] hi,
                              input logic [ADDR_W-1:0] base);
      wr_t w;
      exp_q.delete();
      for (int k = 0; k < 2 * LANES; k++) begin
         w.addr = ADDR_W'((int'(base) + k) % (1 << ADDR_W));
         w.data = (k < LANES) ? lo[WORD_W*k +: WORD_W] : hi[WORD_W*(k-LANES) +: WORD_W];
         exp_q.push_back(w);
      end
   endtask

   // ready_mode: 0 always ready, 1 ready on odd cycles only, 2 random.
   task automatic transfer(input logic [VEC_W-1:0] lo, input logic [VEC_W-1:0] hi,
                           input logic [ADDR_W-1:0] base, input int ready_mode,
                           input bit keep_start, input bit poke_start,
                           input int rst_after, output int done_cyc);
      int  cyc;
      int  accepted;
      bit  seen_done;
      check("idle_before_start", busy, 0);
      res_lo    = lo;
      res_hi    = hi;
      base_addr = base;
      start     = 1'b1;
      mem_ready = 1'b1;
      build_model(lo, hi, base);
      tick();
      cyc       = 1;
      accepted  = 0;
      seen_done = 1'b0;
      done_cyc  = -1;
      while (cyc < 400) begin
         res_lo    = rand_vec();
         res_hi    = rand_vec();
         base_addr = ADDR_W'($urandom);
         if (rst_after >= 0 && accepted == rst_after) begin
            rst = 1'b1;
            #1;
            check("rst_we", mem_we, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_addr", mem_addr, 0);
            check("rst_wdata", mem_wdata, 0);
            tick();
            tick();
            check("rst_hold_done", done, 0);
            check("rst_hold_we", mem_we, 0);
            rst   = 1'b0;
            start = 1'b0;
            tick();
            check("post_rst_busy", busy, 0);
            check("post_rst_done", done, 0);
            return;
         end
         if (done) begin
            seen_done = 1'b1;
            done_cyc  = cyc;
            check("done_all_written", exp_q.size(), 0);
            check("finish_busy", busy, 1);
            check("finish_we", mem_we, 0);
            check("finish_addr", mem_addr, 0);
            check("finish_wdata", mem_wdata, 0);
            tick();
            check("after_done_busy", busy, 0);
            check("after_done_done", done, 0);
            break;
         end
         check("xfer_busy", busy, 1);
         check("xfer_we", mem_we, 1);
         if (exp_q.size() == 0) begin
            check("extra_write", exp_q.size(), 1);
         end else begin
            check("wr_addr", mem_addr, exp_q[0].addr);
            check("wr_data", mem_wdata, exp_q[0].data);
         end
         case (ready_mode)
            0:       mem_ready = 1'b1;
            1:       mem_ready = (cyc % 2 == 1);
            default: mem_ready = ($urandom_range(0, 3) != 0);
         endcase
         start = keep_start || (poke_start && exp_q.size() == LANES - 2);
         if (start && !keep_start) res_lo = '0;
         if (mem_ready && mem_we && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            accepted++;
         end
         tick();
         cyc++;
      end
      start = keep_start;
      if (rst_after < 0) check("done_seen", seen_done, 1);
   endtask

   logic [VEC_W-1:0] v_lo;
   logic [VEC_W-1:0] v_hi;
   int               dcyc;

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      res_lo    = '0;
      res_hi    = '0;
      base_addr = '0;
      mem_ready = 1'b0;
      #2;
      check("reset_we", mem_we, 0);
      check("reset_addr", mem_addr, 0);
      check("reset_wdata", mem_wdata, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      check("idle_busy", busy, 0);

      for (int i = 0; i < LANES; i++) v_lo[WORD_W*i +: WORD_W] = WORD_W'(i + 1);
      v_hi = '1;
      transfer(v_lo, v_hi, 10'h100, 0, 1'b0, 1'b0, -1, dcyc);
      check("latency_ready", dcyc, 2 * LANES + 1);

      transfer(v_lo, v_hi, 10'h100, 1, 1'b0, 1'b0, -1, dcyc);
      check("latency_alt_stall", dcyc, 4 * LANES);

      transfer(rand_vec(), rand_vec(), 10'h3F8, 0, 1'b0, 1'b0, -1, dcyc);
      check("latency_wrap", dcyc, 2 * LANES + 1);

      transfer(rand_vec(), rand_vec(), ADDR_W'($urandom), 2, 1'b0, 1'b1, -1, dcyc);

      transfer(rand_vec(), rand_vec(), ADDR_W'($urandom), 0, 1'b0, 1'b0, 5, dcyc);
      transfer(v_lo, v_hi, 10'h000, 0, 1'b0, 1'b0, -1, dcyc);
      check("latency_after_rst", dcyc, 2 * LANES + 1);

      for (int t = 0; t < 3; t++) begin
         transfer(rand_vec(), rand_vec(), ADDR_W'($urandom), 0, 1'b1, 1'b0, -1, dcyc);
         check("latency_b2b", dcyc, 2 * LANES + 1);
      end
      start = 1'b0;
      tick();

      for (int t = 0; t < 4; t++) begin
         transfer(rand_vec(), rand_vec(), ADDR_W'($urandom), 2, 1'b0, 1'b0, -1, dcyc);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
